// File: rtl/tcam_access_ctrl.sv
// ============================================================================
// Module   : tcam_access_ctrl
// Brief    : Clears the TCAM array after reset/clear requests, then arbitrates
//            row writes against pipelined priority-match searches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tcam_access_ctrl #(
  parameter int STARVE_LIM = 4
) (
  input  logic        in_clk,
  input  logic        in_rstn,
  input  logic        in_clr,
  input  logic        in_wr_valid,
  output logic        out_wr_ready,
  input  logic [9:0]  in_wr_addr,
  input  logic [31:0] in_wr_data,
  input  logic [3:0]  in_wr_mask,
  input  logic        in_srch_valid,
  output logic        out_srch_ready,
  input  logic [27:0] in_srch_key,
  input  logic [3:0]  in_srch_tag,
  output logic        out_rsp_valid,
  output logic [5:0]  out_rsp_pma,
  output logic [3:0]  out_rsp_tag,
  output logic        out_tcam_csb,
  output logic        out_tcam_web,
  output logic [3:0]  out_tcam_wmask,
  output logic [27:0] out_tcam_addr,
  output logic [31:0] out_tcam_wdata,
  input  logic [5:0]  in_tcam_pma,
  output logic        out_init_busy
);

  localparam int c_starve_w = $clog2(STARVE_LIM + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIM);
  localparam logic [9:0] c_last_row = 10'd1023;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [9:0]            r_clr_cnt;
  logic [c_starve_w-1:0] r_starve;

  logic        r_csb;
  logic        r_web;
  logic [3:0]  r_wmask;
  logic [27:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_s1_vld;
  logic [3:0]  r_s1_tag;
  logic        r_s2_vld;
  logic [3:0]  r_s2_tag;
  logic        r_rsp_vld;
  logic [5:0]  r_rsp_pma;
  logic [3:0]  r_rsp_tag;

  logic w_open;
  logic w_force;
  logic w_wr_go;
  logic w_srch_go;

  // A saturated starvation count flips priority to the search side for one grant.
  assign w_open         = (r_state == ST_RUN) && !in_clr;
  assign w_force        = (r_starve == c_starve_max);
  assign out_wr_ready   = w_open && !w_force;
  assign out_srch_ready = w_open && (!in_wr_valid || w_force);
  assign w_wr_go        = in_wr_valid && out_wr_ready;
  assign w_srch_go      = in_srch_valid && out_srch_ready;

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= 10'd0;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_wmask   <= 4'h0;
      r_addr    <= 28'h0;
      r_wdata   <= 32'h0;
    end else begin
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      r_addr  <= 28'h0;
      r_wdata <= 32'h0;
      case (r_state)
        ST_INIT: begin
          if (in_clr) begin
            r_clr_cnt <= 10'd0;
          end else begin
            r_csb     <= 1'b0;
            r_web     <= 1'b0;
            r_wmask   <= 4'hF;
            r_addr    <= {18'b0, r_clr_cnt};
            r_clr_cnt <= r_clr_cnt + 10'd1;
            if (r_clr_cnt == c_last_row) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (in_clr) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= 10'd0;
          end else if (w_wr_go) begin
            r_csb   <= 1'b0;
            r_web   <= 1'b0;
            r_wmask <= in_wr_mask;
            r_addr  <= {18'b0, in_wr_addr};
            r_wdata <= in_wr_data;
          end else if (w_srch_go) begin
            r_csb  <= 1'b0;
            r_addr <= in_srch_key;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      r_starve <= '0;
    end else if (w_srch_go) begin
      r_starve <= '0;
    end else if (in_srch_valid && !w_force) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Search pipeline ignores in_clr so in-flight lookups still return.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      r_s1_vld  <= 1'b0;
      r_s1_tag  <= 4'h0;
      r_s2_vld  <= 1'b0;
      r_s2_tag  <= 4'h0;
      r_rsp_vld <= 1'b0;
      r_rsp_pma <= 6'h0;
      r_rsp_tag <= 4'h0;
    end else begin
      r_s1_vld  <= w_srch_go;
      if (w_srch_go) begin
        r_s1_tag <= in_srch_tag;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_tag  <= r_s1_tag;
      r_rsp_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_rsp_pma <= in_tcam_pma;
        r_rsp_tag <= r_s2_tag;
      end
    end
  end

  assign out_tcam_csb   = r_csb;
  assign out_tcam_web   = r_web;
  assign out_tcam_wmask = r_wmask;
  assign out_tcam_addr  = r_addr;
  assign out_tcam_wdata = r_wdata;
  assign out_rsp_valid  = r_rsp_vld;
  assign out_rsp_pma    = r_rsp_pma;
  assign out_rsp_tag    = r_rsp_tag;
  assign out_init_busy  = (r_state == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_tcam_access_ctrl.sv
// ============================================================================
// Module   : tb_tcam_access_ctrl
// Brief    : Scoreboard bench for tcam_access_ctrl with a behavioural TCAM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tcam_access_ctrl;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        clr = 1'b0;
  logic        wr_valid = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic        srch_valid = 1'b0;
  logic [27:0] srch_key = '0;
  logic [3:0]  srch_tag = '0;
  logic [5:0]  tcam_pma = '0;

  logic        wr_ready, srch_ready, rsp_valid, init_busy;
  logic [5:0]  rsp_pma;
  logic [3:0]  rsp_tag;
  logic        tcam_csb, tcam_web;
  logic [3:0]  tcam_wmask;
  logic [27:0] tcam_addr;
  logic [31:0] tcam_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcam_access_ctrl #(.STARVE_LIM(LIM)) dut (
    .in_clk(clk), .in_rstn(rstn), .in_clr(clr),
    .in_wr_valid(wr_valid), .out_wr_ready(wr_ready),
    .in_wr_addr(wr_addr), .in_wr_data(wr_data), .in_wr_mask(wr_mask),
    .in_srch_valid(srch_valid), .out_srch_ready(srch_ready),
    .in_srch_key(srch_key), .in_srch_tag(srch_tag),
    .out_rsp_valid(rsp_valid), .out_rsp_pma(rsp_pma), .out_rsp_tag(rsp_tag),
    .out_tcam_csb(tcam_csb), .out_tcam_web(tcam_web), .out_tcam_wmask(tcam_wmask),
    .out_tcam_addr(tcam_addr), .out_tcam_wdata(tcam_wdata),
    .in_tcam_pma(tcam_pma), .out_init_busy(init_busy)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Array content stand-in: one key has a fixed answer, others hash.
  function automatic logic [5:0] pma_of(input logic [27:0] k);
    if (k == 28'h0ABCDEF) return 6'd17;
    return k[5:0] ^ k[11:6] ^ k[17:12] ^ k[23:18] ^ {2'b00, k[27:24]};
  endfunction

  always @(posedge clk) begin
    if (!tcam_csb && tcam_web) tcam_pma <= pma_of(tcam_addr);
    else                       tcam_pma <= 6'($urandom);
  end

  // Reference model
  typedef struct {
    logic [5:0] pma;
    logic [3:0] tag;
    int         due;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        e;
  bit          m_init;
  int          m_cnt, m_starve, cyc;
  bit          m_sgrant;
  logic        m_csb, m_web;
  logic [3:0]  m_wmask;
  logic [27:0] m_addr;
  logic [31:0] m_wdata;
  logic [5:0]  last_pma;
  logic [3:0]  last_tag;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_init = 1; m_cnt = 0; m_starve = 0;
      {m_csb, m_web, m_wmask, m_addr, m_wdata} = {1'b1, 1'b1, 4'h0, 28'h0, 32'h0};
      last_pma = 0; last_tag = 0;
      sb.delete();
    end else begin
      cyc++;
      m_sgrant = 0;
      {m_csb, m_web, m_wmask, m_addr, m_wdata} = {1'b1, 1'b1, 4'h0, 28'h0, 32'h0};
      if (clr) begin
        m_init = 1; m_cnt = 0;
      end else if (m_init) begin
        {m_csb, m_web, m_wmask, m_addr} = {1'b0, 1'b0, 4'hF, 28'(m_cnt)};
        if (m_cnt == 1023) begin m_init = 0; m_cnt = 0; end
        else m_cnt++;
      end else if (wr_valid && m_starve != LIM) begin
        {m_csb, m_web, m_wmask, m_addr, m_wdata} = {1'b0, 1'b0, wr_mask, 18'h0, wr_addr, wr_data};
      end else if (srch_valid) begin
        {m_csb, m_web, m_addr} = {1'b0, 1'b1, srch_key};
        sb.push_back('{pma_of(srch_key), srch_tag, cyc + 2});
        m_sgrant = 1;
      end
      if (m_sgrant) m_starve = 0;
      else if (srch_valid && m_starve < LIM) m_starve++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rstn) begin
      check("wr_ready", wr_ready, !m_init && !clr && m_starve != LIM);
      check("srch_ready", srch_ready, !m_init && !clr && (!wr_valid || m_starve == LIM));
      check("init_busy", init_busy, m_init);
      check("port_drive", {tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata},
            {m_csb, m_web, m_wmask, m_addr, m_wdata});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_pma", rsp_pma, e.pma);
          check("rsp_latency", cyc, e.due);
          last_pma = e.pma; last_tag = e.tag;
        end
      end else begin
        check("rsp_hold", {rsp_pma, rsp_tag}, {last_pma, last_tag});
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          check("rsp_missing", cyc, e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    clr = 0; wr_valid = 0; srch_valid = 0;
  endtask

  task automatic rand_in(input int clr_odds);
    wr_valid   = 1'($urandom_range(0, 1));
    srch_valid = 1'($urandom_range(0, 1));
    wr_addr    = 10'($urandom);
    wr_data    = $urandom;
    wr_mask    = 4'($urandom);
    srch_key   = 28'($urandom);
    srch_tag   = 4'($urandom);
    clr        = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  task automatic wait_init_done(input bit randomize_in);
    for (int i = 0; i < 1100 && init_busy; i++) begin
      if (randomize_in) rand_in(0); else idle_in();
      step();
    end
    idle_in();
    check("init_timeout", init_busy, 1'b0);
  endtask

  logic [9:0] grant_seq;
  int         n_clear;

  initial begin
    #1 rstn = 0;
    #1;
    check("rst_busy", init_busy, 1'b1);
    check("rst_ready", {wr_ready, srch_ready}, 2'b00);
    check("rst_drive", {tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata}, {2'b11, 64'h0});
    check("rst_rsp", {rsp_valid, rsp_pma, rsp_tag}, 11'h0);
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    // Initial clear with random requesters pushing against closed readies
    wait_init_done(1);
    step();

    // Single search with a known array answer
    srch_valid = 1; srch_key = 28'h0ABCDEF; srch_tag = 4'd5;
    step();
    check("srch_drive", {tcam_csb, tcam_web, tcam_addr}, {1'b0, 1'b1, 28'h0ABCDEF});
    idle_in();
    repeat (3) step();

    // Three back-to-back searches
    for (int t = 1; t <= 3; t++) begin
      srch_valid = 1; srch_tag = 4'(t); srch_key = 28'($urandom);
      step();
    end
    idle_in();
    repeat (4) step();

    // Continuous contention: expect four writes then one search, twice
    srch_valid = 1; wr_valid = 0;
    step();
    wr_valid = 1;
    grant_seq = '0;
    for (int i = 0; i < 10; i++) begin
      wr_addr = 10'($urandom); wr_data = $urandom; srch_key = 28'($urandom);
      step();
      grant_seq = {grant_seq[8:0], (!tcam_csb && tcam_web)};
    end
    check("grant_pattern", grant_seq, 10'b0000100001);
    idle_in();
    repeat (3) step();

    // Randomized traffic with occasional clear requests
    for (int i = 0; i < 600; i++) begin
      rand_in(300);
      step();
    end
    idle_in();
    wait_init_done(0);
    repeat (3) step();

    // Clear taken while a search is in flight
    srch_valid = 1; srch_key = 28'($urandom); srch_tag = 4'd9;
    step();
    idle_in(); clr = 1;
    step();
    clr = 0;
    n_clear = 0;
    for (int i = 0; i < 1100 && init_busy; i++) begin
      rand_in(0);
      step();
      if (!tcam_csb && !tcam_web) n_clear++;
    end
    idle_in();
    check("clear_writes", n_clear, 1024);
    check("inflight_drained", sb.size(), 0);

    // Reset pulsed mid-clear at row 500
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 600 && !(tcam_addr == 28'd500 && init_busy); i++) step();
    check("reach_row500", tcam_addr, 28'd500);
    #2 rstn = 0;
    #1;
    check("rst_mid_drive", {tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata}, {2'b11, 64'h0});
    check("rst_mid_ready", {wr_ready, srch_ready, init_busy}, 3'b001);
    @(posedge clk); #1 rstn = 1;
    step();
    check("restart_row0", {tcam_csb, tcam_web, tcam_addr}, {2'b00, 28'd0});
    wait_init_done(0);

    for (int i = 0; i < 200; i++) begin
      rand_in(0);
      step();
    end
    idle_in();
    repeat (5) step();
    check("final_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/tcam_access_ctrl.md
TCAM_ACCESS_CTRL -- requirements
Module: tcam_access_ctrl

Interface
REQ-001 Parameter STARVE_LIM, default 4: consecutive lost arbitration cycles before a pending search is forced through.
REQ-002 in_clk  input  1  single clock, all state on rising edge.
REQ-003 in_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 in_clr  input  1  request to re-run the array clear sequence.
REQ-005 in_wr_valid / out_wr_ready  in/out  1/1  write requester handshake.
REQ-006 in_wr_addr  input  10  array row address, {block[1:0], row[7:0]}.
REQ-007 in_wr_data, in_wr_mask  input  32, 4  row write data and byte mask.
REQ-008 in_srch_valid / out_srch_ready  in/out  1/1  search requester handshake.
REQ-009 in_srch_key, in_srch_tag  input  28, 4  search key and requester tag.
REQ-010 out_rsp_valid, out_rsp_pma, out_rsp_tag  output  1, 6, 4  search result.
REQ-011 out_tcam_csb, out_tcam_web, out_tcam_wmask, out_tcam_addr, out_tcam_wdata  output  1, 1, 4, 28, 32  registered drive of the TCAM array ports.
REQ-012 in_tcam_pma  input  6  array priority-match address.
REQ-013 out_init_busy  output  1  clear sequence in progress.

Function
REQ-014 States SHALL be INIT and RUN; in_clr in RUN SHALL move to INIT; INIT SHALL move to RUN after the last clear write.
REQ-015 INIT SHALL issue 1024 writes, one per cycle, addr = 0..1023 ascending, zero-extended to 28 bits, wdata = 0, wmask = 4'hF.
REQ-016 in_clr asserted during INIT SHALL restart the clear counter at 0.
REQ-017 out_wr_ready and out_srch_ready SHALL be 0 in INIT, and 0 in any cycle where in_clr = 1.
REQ-018 In RUN, at most one command per cycle SHALL be granted; a handshake completes when valid & ready are both 1 at a rising edge.
REQ-019 Default arbitration SHALL grant write over search; out_srch_ready = 1 when no write is valid, or when the starvation counter equals STARVE_LIM, in which case out_wr_ready = 0.
REQ-020 The starvation counter SHALL increment each cycle with in_srch_valid = 1 and no search grant, saturate at STARVE_LIM, and clear on a search grant.
REQ-021 Write accepted at edge N: during cycle N+1 the port drive SHALL be csb = 0, web = 0, addr = {18'b0, in_wr_addr}, wdata/wmask = request values.
REQ-022 Search accepted at edge N: during cycle N+1 the port drive SHALL be csb = 0, web = 1, addr = in_srch_key, wmask = 0, wdata = 0.
REQ-023 Cycles without a command SHALL drive csb = 1, web = 1, addr = 0, wmask = 0, wdata = 0.
REQ-024 The controller SHALL register in_tcam_pma at edge N+2 and assert out_rsp_valid for exactly one cycle after edge N+2 with the accepted tag; there is no response backpressure.
REQ-025 Back-to-back searches SHALL be fully pipelined; responses SHALL return in acceptance order, one per cycle.
REQ-026 Searches in flight when in_clr is taken SHALL still produce their responses.
REQ-027 out_rsp_pma and out_rsp_tag SHALL hold their last values while out_rsp_valid = 0.

Reset
REQ-028 With in_rstn = 0: state INIT, clear counter 0, starvation counter 0, out_init_busy = 1, out_rsp_valid/pma/tag = 0, the memory port drive at idle values (REQ-023), both readies 0, and in-flight searches discarded.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without a clock edge; after release the clear sequence SHALL start from address 0.

Verification
REQ-030 Release reset -> 1024 cycles of writes with addr 0..1023, wdata 0, wmask F; out_init_busy falls and both readies may rise only afterwards.
REQ-031 Search key 28'h0ABCDEF, tag 5, accepted at edge N; model returns pma 17 -> cycle N+1 shows csb 0, web 1, addr 0ABCDEF; one-cycle out_rsp_valid after edge N+2 with pma 17, tag 5.
REQ-032 Continuous in_wr_valid and in_srch_valid -> grant pattern of 4 writes then 1 search, repeating.
REQ-033 Three back-to-back searches, tags 1, 2, 3 -> three consecutive response cycles, tags 1, 2, 3 in order.
REQ-034 in_clr pulsed one cycle after a search is accepted -> that search response still delivered; 1024 clear writes follow; readies stay 0 throughout.
REQ-035 in_rstn pulsed low at clear address 500 -> idle port drive immediately; clear restarts at address 0 after release.
